// File: rtl/video_acc_cmd_queue.sv
// video_acc_cmd_queue
//   N_CHAN independent 64-bit command queues, each filled by a pair of 32-bit
//   register writes (low half latched, high half pushes). Each queue feeds one
//   data mover through a valid/ready handshake. Per-channel enable, flush,
//   sticky overflow/sequence errors, saturating completion counters and a
//   registered level interrupt.
//
// Ports
//   aclk, aresetn         clock, asynchronous active-low reset
//   reg_en/reg_we         access strobe / byte enables (write only when 4'hF)
//   reg_addr/reg_wdata    byte address {chan, offset[3:2], ignored[1:0]} / data
//   reg_rdata             registered read data (1-cycle latency)
//   cmd_valid/cmd_data    per-channel head command, channel c at [64c+63:64c]
//   cmd_ready             mover accepts head command
//   done                  per-channel mover completion pulse
//   irq                   registered level interrupt
//
// Register map per channel (offset = reg_addr[3:2])
//   0  W: latch low half, set pend         R: occupancy
//   1  W: push {wdata, low} if pend        R: {empty, full, err, pend}
//   2  W: clear done_cnt and errors        R: done_cnt
//   3  W: {flush, irq_en, enable}          R: {irq_en, enable}
module video_acc_cmd_queue #(
  parameter int unsigned N_CHAN     = 2,
  parameter int unsigned DEPTH_LOG2 = 7,
  parameter int unsigned N_DEST     = 6,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    reg_en,
  input  logic [3:0]              reg_we,
  input  logic [ADDR_W-1:0]       reg_addr,
  input  logic [31:0]             reg_wdata,
  output logic [31:0]             reg_rdata,
  output logic [N_CHAN-1:0]       cmd_valid,
  output logic [64*N_CHAN-1:0]    cmd_data,
  input  logic [N_CHAN-1:0]       cmd_ready,
  input  logic [N_CHAN-1:0]       done,
  output logic                    irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned CH_W  = ADDR_W - 4;

  logic [CH_W-1:0]   addr_ch;
  logic [1:0]        addr_off;
  logic              wr_en;
  logic              unused_addr_lsb;

  logic [31:0]       ch_rd [N_CHAN];
  logic [N_CHAN-1:0] irq_term;

  logic [31:0]       rdata_d, rdata_q;
  logic              irq_d, irq_q;

  assign addr_ch         = reg_addr[ADDR_W-1:4];
  assign addr_off        = reg_addr[3:2];
  assign wr_en           = reg_en & (reg_we == 4'hF);
  assign unused_addr_lsb = ^reg_addr[1:0];

  for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
    logic                  sel;
    logic                  wr0, wr1, wr2, wr3;
    logic                  full, empty, push, pop, flush, valid;
    logic                  dest_ok;
    logic [63:0]           head;
    logic [31:0]           rd_word;

    logic [31:0]           low_d, low_q;
    logic                  pend_d, pend_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_d, wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]      count_d, count_q;
    logic                  seq_err_d, seq_err_q;
    logic                  ovf_err_d, ovf_err_q;
    logic [15:0]           done_cnt_d, done_cnt_q;
    logic                  enable_d, enable_q;
    logic                  irq_en_d, irq_en_q;

    logic [63:0]           mem_q [DEPTH];

    assign sel   = (addr_ch == CH_W'(c));
    assign wr0   = wr_en & sel & (addr_off == 2'd0);
    assign wr1   = wr_en & sel & (addr_off == 2'd1);
    assign wr2   = wr_en & sel & (addr_off == 2'd2);
    assign wr3   = wr_en & sel & (addr_off == 2'd3);

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign flush = wr3 & reg_wdata[2];
    assign push  = wr1 & pend_q & ~full;
    assign valid = enable_q & ~empty;
    assign pop   = valid & cmd_ready[c];

    // Out-of-range destinations are steered to destination 0.
    assign head    = mem_q[rd_ptr_q];
    assign dest_ok = (32'(head[2:0]) < N_DEST);

    assign cmd_valid[c]        = valid;
    assign cmd_data[64*c +: 64] = {head[63:3], dest_ok ? head[2:0] : 3'b000};

    always_comb begin
      low_d      = low_q;
      pend_d     = pend_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      seq_err_d  = seq_err_q;
      ovf_err_d  = ovf_err_q;
      done_cnt_d = done_cnt_q;
      enable_d   = enable_q;
      irq_en_d   = irq_en_q;

      if (wr0) begin
        low_d  = reg_wdata;
        pend_d = 1'b1;
      end

      if (wr1) begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (full) ovf_err_d = 1'b1;
        end else begin
          seq_err_d = 1'b1;
        end
      end

      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      // Flush discards any simultaneous pop; pushes cannot coincide because
      // they use a different register offset.
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        pend_d   = 1'b0;
      end

      if (wr3) begin
        enable_d = reg_wdata[0];
        irq_en_d = reg_wdata[1];
      end

      // Clear wins over a coincident done pulse.
      if (wr2) begin
        seq_err_d  = 1'b0;
        ovf_err_d  = 1'b0;
        done_cnt_d = '0;
      end else if (done[c] && (done_cnt_q != '1)) begin
        done_cnt_d = done_cnt_q + 16'd1;
      end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        low_q      <= '0;
        pend_q     <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        seq_err_q  <= 1'b0;
        ovf_err_q  <= 1'b0;
        done_cnt_q <= '0;
        enable_q   <= 1'b1;
        irq_en_q   <= 1'b0;
      end else begin
        low_q      <= low_d;
        pend_q     <= pend_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        seq_err_q  <= seq_err_d;
        ovf_err_q  <= ovf_err_d;
        done_cnt_q <= done_cnt_d;
        enable_q   <= enable_d;
        irq_en_q   <= irq_en_d;
      end
    end

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= {reg_wdata, low_q};
    end

    always_comb begin
      rd_word = '0;
      unique case (addr_off)
        2'd0: rd_word = 32'(count_q);
        2'd1: rd_word = {28'b0, empty, full, seq_err_q | ovf_err_q, pend_q};
        2'd2: rd_word = {16'b0, done_cnt_q};
        2'd3: rd_word = {30'b0, irq_en_q, enable_q};
        default: rd_word = '0;
      endcase
    end

    assign ch_rd[c]    = rd_word;
    assign irq_term[c] = irq_en_q & ((done_cnt_q != '0) | ovf_err_q | seq_err_q);
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      if (addr_ch == CH_W'(c)) rdata_d = ch_rd[c];
    end
  end

  assign irq_d = |irq_term;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (reg_en) rdata_q <= rdata_d;
      irq_q <= irq_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign irq       = irq_q;

endmodule
